// File: rtl/uart_frame_unpack.sv
// ---------------------------------------------------------------------------
// uart_frame_unpack
//   Receive-side parser for the fixed 32-byte UART frame:
//     55 BB 01 1A <26 payload bytes> <CRC8> F0
//   Hunts the header, collects the payload into a shadow buffer, feeds frame
//   bytes 2..29 to an external CRC8 engine, compares the received CRC byte to
//   the engine's running value, checks the tail, and publishes the payload
//   only for good frames.
//
// Ports
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   rd_vld          in   one-cycle strobe, rd_data holds a received byte
//   rd_data         in   received byte
//   rx_crc_din_vld  out  byte to CRC engine valid (one cycle)
//   rx_crc_din      out  byte to CRC engine (0 when not valid)
//   rx_crc_dout     in   running CRC8 over bytes presented so far
//   rx_crc_done     out  pulse: frame ended/aborted, CRC engine reinitialises
//   rx_frame_data   out  payload, byte k at [8k+7:8k]; held until next good frame
//   rx_frame_vld    out  pulse: good frame, rx_frame_data updated same edge
//   rx_crc_err      out  pulse: structure ok, CRC mismatch
//   rx_frame_err    out  pulse: bad tail or inter-byte timeout
// ---------------------------------------------------------------------------
module uart_frame_unpack #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_vld,
    input  logic [7:0]   rd_data,
    output logic         rx_crc_din_vld,
    output logic [7:0]   rx_crc_din,
    input  logic [7:0]   rx_crc_dout,
    output logic         rx_crc_done,
    output logic [207:0] rx_frame_data,
    output logic         rx_frame_vld,
    output logic         rx_crc_err,
    output logic         rx_frame_err
);

    localparam int unsigned PAY_BYTES = 26;
    localparam int unsigned PAY_W     = 5;
    localparam int unsigned DATA_W    = 8 * PAY_BYTES;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] HDR0_BYTE = 8'h55;
    localparam logic [7:0] HDR1_BYTE = 8'hBB;
    localparam logic [7:0] HDR2_BYTE = 8'h01;
    localparam logic [7:0] HDR3_BYTE = 8'h1A;
    localparam logic [7:0] TAIL_BYTE = 8'hF0;

    localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(PAY_BYTES - 1);
    // Counter value on the cycle whose increment would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR1 = 3'd1,
        S_HDR2 = 3'd2,
        S_HDR3 = 3'd3,
        S_PAY  = 3'd4,
        S_CRC  = 3'd5,
        S_TAIL = 3'd6
    } state_t;

    state_t              state;
    logic [PAY_W-1:0]    pay_cnt;
    logic [CNT_W-1:0]    idle_cnt;
    logic [DATA_W-1:0]   shadow;
    logic                crc_ok;

    // Re-hunt target after a rejected byte: a 55 may itself start a new frame.
    function automatic state_t rehunt(input logic [7:0] b);
        return (b == HDR0_BYTE) ? S_HDR1 : S_IDLE;
    endfunction

    // Bit offset of the current payload byte inside the shadow buffer.
    logic [7:0] pay_bit;
    assign pay_bit = {pay_cnt, 3'b000};

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            pay_cnt        <= '0;
            idle_cnt       <= '0;
            shadow         <= '0;
            crc_ok         <= 1'b0;
            rx_crc_din_vld <= 1'b0;
            rx_crc_din     <= '0;
            rx_crc_done    <= 1'b0;
            rx_frame_data  <= '0;
            rx_frame_vld   <= 1'b0;
            rx_crc_err     <= 1'b0;
            rx_frame_err   <= 1'b0;
        end else begin
            rx_crc_din_vld <= 1'b0;
            rx_crc_din     <= '0;
            rx_crc_done    <= 1'b0;
            rx_frame_vld   <= 1'b0;
            rx_crc_err     <= 1'b0;
            rx_frame_err   <= 1'b0;

            if (rd_vld) begin
                // A received byte always restarts the inter-byte timer.
                idle_cnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (rd_data == HDR0_BYTE) begin
                            state <= S_HDR1;
                        end
                    end

                    S_HDR1: begin
                        if (rd_data == HDR1_BYTE) begin
                            state <= S_HDR2;
                        end else begin
                            state <= rehunt(rd_data);
                        end
                    end

                    S_HDR2: begin
                        if (rd_data == HDR2_BYTE) begin
                            state          <= S_HDR3;
                            rx_crc_din_vld <= 1'b1;
                            rx_crc_din     <= rd_data;
                        end else begin
                            state <= rehunt(rd_data);
                        end
                    end

                    S_HDR3: begin
                        if (rd_data == HDR3_BYTE) begin
                            state          <= S_PAY;
                            pay_cnt        <= '0;
                            rx_crc_din_vld <= 1'b1;
                            rx_crc_din     <= rd_data;
                        end else begin
                            // 01 already reached the CRC engine; flush it.
                            state       <= rehunt(rd_data);
                            rx_crc_done <= 1'b1;
                        end
                    end

                    S_PAY: begin
                        shadow[pay_bit +: 8] <= rd_data;
                        rx_crc_din_vld       <= 1'b1;
                        rx_crc_din           <= rd_data;
                        if (pay_cnt == PAY_LAST) begin
                            state <= S_CRC;
                        end else begin
                            pay_cnt <= pay_cnt + PAY_W'(1);
                        end
                    end

                    S_CRC: begin
                        // Engine has absorbed all 28 covered bytes by now.
                        crc_ok <= (rd_data == rx_crc_dout);
                        state  <= S_TAIL;
                    end

                    S_TAIL: begin
                        if (rd_data == TAIL_BYTE) begin
                            if (crc_ok) begin
                                rx_frame_vld  <= 1'b1;
                                rx_frame_data <= shadow;
                            end else begin
                                rx_crc_err <= 1'b1;
                            end
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                        rx_crc_done <= 1'b1;
                        state       <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE) begin
                // Inter-byte timeout only applies once a frame has started.
                if (idle_cnt == TO_LAST) begin
                    idle_cnt     <= '0;
                    rx_frame_err <= 1'b1;
                    rx_crc_done  <= 1'b1;
                    state        <= S_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_unpack.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_unpack
//   Self-checking bench: drives byte strobes, emulates the CRC8 engine
//   (poly 0x07, init 0), and compares every DUT output each cycle against a
//   byte-stream reference model. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_frame_unpack;

    localparam int unsigned T = 40;

    logic         clk;
    logic         reset;
    logic         rd_vld;
    logic [7:0]   rd_data;
    logic         rx_crc_din_vld;
    logic [7:0]   rx_crc_din;
    logic [7:0]   rx_crc_dout;
    logic         rx_crc_done;
    logic [207:0] rx_frame_data;
    logic         rx_frame_vld;
    logic         rx_crc_err;
    logic         rx_frame_err;

    uart_frame_unpack #(.TIMEOUT_CYCLES(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .rx_crc_din_vld (rx_crc_din_vld),
        .rx_crc_din     (rx_crc_din),
        .rx_crc_dout    (rx_crc_dout),
        .rx_crc_done    (rx_crc_done),
        .rx_frame_data  (rx_frame_data),
        .rx_frame_vld   (rx_frame_vld),
        .rx_crc_err     (rx_crc_err),
        .rx_frame_err   (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse counters seen on DUT outputs (for directed literal checks).
    int n_vld = 0, n_cerr = 0, n_ferr = 0, n_din = 0, n_done = 0;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [207:0] act, input logic [207:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // CRC8 engine emulation.
    logic [7:0] eng;
    always @(posedge clk) begin
        if (reset || rx_crc_done) eng <= 8'h00;
        else if (rx_crc_din_vld)  eng <= crc8_step(eng, rx_crc_din);
    end
    assign rx_crc_dout = eng;

    // Reference model: tracks the bytes of the candidate frame as a queue.
    logic [7:0]   cur [$];
    logic [7:0]   hdr [4];
    int           idle;
    logic [207:0] m_data;
    logic         e_din_vld, e_done, e_vld, e_cerr, e_ferr;
    logic [7:0]   e_din;

    initial begin
        hdr[0] = 8'h55; hdr[1] = 8'hBB; hdr[2] = 8'h01; hdr[3] = 8'h1A;
        idle   = 0;
        m_data = '0;
        forever begin
            logic v, r;
            logic [7:0] d;
            int n;
            logic [7:0] crc;
            @(posedge clk);
            v = rd_vld; d = rd_data; r = reset;
            #1;
            e_din_vld = 0; e_din = 0; e_done = 0; e_vld = 0; e_cerr = 0; e_ferr = 0;
            if (r) begin
                cur.delete(); idle = 0; m_data = '0;
            end else if (v) begin
                idle = 0;
                if (cur.size() == 0) begin
                    if (d == 8'h55) cur.push_back(d);
                end else begin
                    cur.push_back(d);
                    n = cur.size();
                    if (n <= 4 && d != hdr[n-1]) begin
                        if (n == 4) e_done = 1;
                        cur.delete();
                        if (d == 8'h55) cur.push_back(d);
                    end else begin
                        if (n >= 3 && n <= 30) begin e_din_vld = 1; e_din = d; end
                        if (n == 32) begin
                            crc = 8'h00;
                            for (int i = 2; i <= 29; i++) crc = crc8_step(crc, cur[i]);
                            e_done = 1;
                            if (cur[31] != 8'hF0)   e_ferr = 1;
                            else if (crc != cur[30]) e_cerr = 1;
                            else begin
                                e_vld = 1;
                                for (int k = 0; k < 26; k++) m_data[8*k +: 8] = cur[4+k];
                            end
                            cur.delete();
                        end
                    end
                end
            end else if (cur.size() != 0) begin
                idle++;
                if (idle == int'(T)) begin
                    e_ferr = 1; e_done = 1; cur.delete(); idle = 0;
                end
            end
            chk("din_vld",   208'(rx_crc_din_vld), 208'(e_din_vld));
            chk("din",       208'(rx_crc_din),     208'(e_din));
            chk("crc_done",  208'(rx_crc_done),    208'(e_done));
            chk("frame_vld", 208'(rx_frame_vld),   208'(e_vld));
            chk("crc_err",   208'(rx_crc_err),     208'(e_cerr));
            chk("frame_err", 208'(rx_frame_err),   208'(e_ferr));
            chk("frame_data", rx_frame_data,       m_data);
            if (rx_frame_vld === 1'b1)   n_vld++;
            if (rx_crc_err === 1'b1)     n_cerr++;
            if (rx_frame_err === 1'b1)   n_ferr++;
            if (rx_crc_din_vld === 1'b1) n_din++;
            if (rx_crc_done === 1'b1)    n_done++;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] pay [26];

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rd_vld  = 1'b1;
        rd_data = b;
        @(negedge clk);
        rd_vld  = 1'b0;
        rd_data = $urandom_range(0, 255);
        repeat (gap) @(negedge clk);
    endtask

    function automatic int rgap();
        return int'($urandom_range(1, 3));
    endfunction

    task automatic send_header_pay(input int npay);
        send_byte(8'h55, rgap()); send_byte(8'hBB, rgap());
        send_byte(8'h01, rgap()); send_byte(8'h1A, rgap());
        for (int k = 0; k < npay; k++) send_byte(pay[k], rgap());
    endtask

    task automatic send_frame(input logic [7:0] crc_x, input logic [7:0] tail, input int tail_gap);
        logic [7:0] c;
        c = crc8_step(8'h00, 8'h01);
        c = crc8_step(c, 8'h1A);
        for (int k = 0; k < 26; k++) c = crc8_step(c, pay[k]);
        send_header_pay(26);
        send_byte(c ^ crc_x, rgap());
        send_byte(tail, tail_gap);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 26; k++) pay[k] = 8'(k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 26; k++) pay[k] = 8'($urandom_range(0, 255));
    endtask

    int s_vld, s_cerr, s_ferr, s_din, s_done;
    task automatic snap();
        s_vld = n_vld; s_cerr = n_cerr; s_ferr = n_ferr; s_din = n_din; s_done = n_done;
    endtask

    initial begin
        reset   = 1'b1;
        rd_vld  = 1'b0;
        rd_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_vld",  208'(rx_frame_vld), 208'(0));
        chk("rst_data", rx_frame_data,      208'(0));
        chk("rst_din",  208'(rx_crc_din),   208'(0));
        chk("rst_done", 208'(rx_crc_done),  208'(0));
        reset = 1'b0;
        settle();

        // Good frame with ramp payload.
        fill_ramp(); snap();
        send_frame(8'h00, 8'hF0, 1); settle();
        chk("good_vld_cnt",  208'(n_vld - s_vld),   208'(1));
        chk("good_din_cnt",  208'(n_din - s_din),   208'(28));
        chk("good_done_cnt", 208'(n_done - s_done), 208'(1));
        chk("good_byte0",    208'(rx_frame_data[7:0]),     208'(8'h00));
        chk("good_byte25",   208'(rx_frame_data[207:200]), 208'(8'h19));

        // CRC corrupted.
        snap();
        send_frame(8'h01, 8'hF0, 1); settle();
        chk("crcbad_err_cnt", 208'(n_cerr - s_cerr), 208'(1));
        chk("crcbad_vld_cnt", 208'(n_vld - s_vld),   208'(0));
        chk("crcbad_hold",    208'(rx_frame_data[207:200]), 208'(8'h19));

        // Bad tail.
        snap();
        send_frame(8'h00, 8'h0F, 1); settle();
        chk("tail_ferr_cnt", 208'(n_ferr - s_ferr), 208'(1));
        chk("tail_done_cnt", 208'(n_done - s_done), 208'(1));

        // Repeated 55 before header.
        snap();
        send_byte(8'h55, 1);
        send_frame(8'h00, 8'hF0, 1); settle();
        chk("rep55_vld_cnt", 208'(n_vld - s_vld), 208'(1));

        // 55 BB 02: nothing reaches the CRC engine.
        snap();
        send_byte(8'h55, 1); send_byte(8'hBB, 1); send_byte(8'h02, 1); settle();
        chk("hdr2_din_cnt",  208'(n_din - s_din),   208'(0));
        chk("hdr2_done_cnt", 208'(n_done - s_done), 208'(0));

        // 55 BB 01 77: one byte to CRC, then flushed.
        snap();
        send_byte(8'h55, 1); send_byte(8'hBB, 1); send_byte(8'h01, 1); send_byte(8'h77, 1); settle();
        chk("hdr3_din_cnt",  208'(n_din - s_din),   208'(1));
        chk("hdr3_done_cnt", 208'(n_done - s_done), 208'(1));

        // Timeout after payload byte 10, then a good frame.
        snap();
        fill_rand();
        send_header_pay(11);
        repeat (T + 5) @(negedge clk);
        chk("to_ferr_cnt", 208'(n_ferr - s_ferr), 208'(1));
        send_frame(8'h00, 8'hF0, 1); settle();
        chk("to_next_vld", 208'(n_vld - s_vld), 208'(1));

        // Back-to-back frames, no gap after the tail.
        snap();
        fill_rand(); send_frame(8'h00, 8'hF0, 0);
        fill_rand(); send_frame(8'h00, 8'hF0, 1); settle();
        chk("b2b_vld_cnt", 208'(n_vld - s_vld), 208'(2));

        // Reset mid-payload.
        fill_rand();
        send_header_pay(5);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #2;
        chk("midrst_din_vld", 208'(rx_crc_din_vld), 208'(0));
        chk("midrst_done",    208'(rx_crc_done),    208'(0));
        chk("midrst_ferr",    208'(rx_frame_err),   208'(0));
        chk("midrst_data",    rx_frame_data,        208'(0));
        @(negedge clk); reset = 1'b0;
        snap();
        fill_ramp(); send_frame(8'h00, 8'hF0, 1); settle();
        chk("midrst_next_vld", 208'(n_vld - s_vld),   208'(1));
        chk("midrst_next_b25", 208'(rx_frame_data[207:200]), 208'(8'h19));

        // Randomized mix; the model checks every cycle.
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            fill_rand();
            case (kind)
                0: send_frame(8'h00, 8'hF0, rgap());
                1: send_frame(8'($urandom_range(1, 255)), 8'hF0, rgap());
                2: send_frame(8'h00, 8'($urandom_range(0, 239)), rgap());
                3: begin
                    int nj;
                    nj = int'($urandom_range(1, 6));
                    for (int j = 0; j < nj; j++) begin
                        logic [7:0] b;
                        case ($urandom_range(0, 4))
                            0: b = 8'h55;
                            1: b = 8'hBB;
                            2: b = 8'h01;
                            3: b = 8'h1A;
                            default: b = 8'($urandom_range(0, 255));
                        endcase
                        send_byte(b, rgap());
                    end
                end
                4: begin
                    send_header_pay(int'($urandom_range(0, 25)));
                    repeat (T + 3) @(negedge clk);
                end
                default: send_frame(8'h00, 8'hF0, rgap());
            endcase
        end
        repeat (T + 5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
